eth_mii_rx_framer: RTL and testbench



---
 rtl/eth_mii_rx_framer.sv | 201 ++++++++++++++++++++
 tb/tb_eth_mii_rx_framer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_mii_rx_framer.sv
// eth_mii_rx_framer: MII nibble-stream receive framer (preamble/SFD strip, byte assembly, length/FCS status).
// Optional CRC-32 check enabled with `define ETH_RX_FCS_CHECK_EN. Revision: 1.0
`default_nettype none

module eth_mii_rx_framer #(
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1518
) (
    input  logic        eth_mac_clock,
    input  logic        eth_mac_rst,
    input  logic        nib_valid,
    input  logic [3:0]  nib_data,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_sof,
    output logic        byte_eof,
    output logic [10:0] frame_len,
    output logic        frame_err,
    output logic        fcs_err,
    output logic [15:0] good_frames,
    output logic [15:0] bad_frames
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_DATA     = 2'd2,
        S_DROP     = 2'd3
    } state_t;

    localparam logic [10:0] c_MIN_LEN = 11'(MIN_FRAME_BYTES);
    localparam logic [10:0] c_MAX_LEN = 11'(MAX_FRAME_BYTES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_sfd;
    logic        w_byte_done;
    logic        w_frame_end;

    logic        r_phase;
    logic [3:0]  r_low;
    logic [7:0]  r_hold;
    logic        r_hold_valid;
    logic        r_first;
    logic [10:0] r_count;

    logic [7:0]  w_new_byte;
    logic        w_keep;
    logic        w_err;
    logic [10:0] w_len;
    logic        w_fcs_bad;

    always_ff @(posedge eth_mac_clock) begin
        if (eth_mac_rst) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sfd       = 1'b0;
        w_byte_done = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (nib_valid) begin
                    if (nib_data == 4'h5) w_state_nxt = S_PREAMBLE;
                    else                  w_state_nxt = S_DROP;
                end
            end
            S_PREAMBLE: begin
                if (!nib_valid) begin
                    w_state_nxt = S_IDLE;
                end else if (nib_data == 4'hD) begin
                    w_state_nxt = S_DATA;
                    w_sfd       = 1'b1;
                end else if (nib_data != 4'h5) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DATA: begin
                if (!nib_valid) begin
                    w_state_nxt = S_IDLE;
                    w_frame_end = 1'b1;
                end else if (r_phase) begin
                    w_byte_done = 1'b1;
                end
            end
            S_DROP: begin
                if (!nib_valid) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_new_byte = {nib_data, r_low};
    assign w_keep     = (r_count < c_MAX_LEN);
    assign w_len      = (r_count > c_MAX_LEN) ? c_MAX_LEN : r_count;
    assign w_err      = r_phase | (r_count < c_MIN_LEN) | (r_count > c_MAX_LEN) | w_fcs_bad;

`ifdef ETH_RX_FCS_CHECK_EN
    logic [31:0] r_crc;

    function automatic logic [31:0] f_crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = (c >> 1);
        end
        return c;
    endfunction

    always_ff @(posedge eth_mac_clock) begin
        if (eth_mac_rst || w_sfd) r_crc <= 32'hFFFFFFFF;
        else if (w_byte_done)     r_crc <= f_crc_byte(r_crc, w_new_byte);
    end

    // Running CRC over data plus FCS leaves the fixed residue on a good frame.
    assign w_fcs_bad = (r_crc != 32'hDEBB20E3);
`else
    assign w_fcs_bad = 1'b0;
`endif

    always_ff @(posedge eth_mac_clock) begin
        if (eth_mac_rst) begin
            r_phase      <= 1'b0;
            r_low        <= 4'h0;
            r_hold       <= 8'h00;
            r_hold_valid <= 1'b0;
            r_first      <= 1'b0;
            r_count      <= 11'd0;
            byte_valid   <= 1'b0;
            byte_data    <= 8'h00;
            byte_sof     <= 1'b0;
            byte_eof     <= 1'b0;
            frame_len    <= 11'd0;
            frame_err    <= 1'b0;
            fcs_err      <= 1'b0;
            good_frames  <= 16'd0;
            bad_frames   <= 16'd0;
        end else begin
            byte_valid <= 1'b0;
            byte_sof   <= 1'b0;
            byte_eof   <= 1'b0;
            frame_len  <= 11'd0;
            frame_err  <= 1'b0;
            fcs_err    <= 1'b0;

            if (w_sfd) begin
                r_phase      <= 1'b0;
                r_count      <= 11'd0;
                r_hold_valid <= 1'b0;
                r_first      <= 1'b1;
            end

            if (r_state == S_DATA && nib_valid) begin
                r_phase <= ~r_phase;
                if (!r_phase) r_low <= nib_data;
            end

            // One-byte hold lets the final byte be tagged with eof when rx_dv drops.
            if (w_byte_done) begin
                if (r_count != 11'h7FF) r_count <= r_count + 11'd1;
                if (w_keep) begin
                    r_hold       <= w_new_byte;
                    r_hold_valid <= 1'b1;
                    if (r_hold_valid) begin
                        byte_valid <= 1'b1;
                        byte_data  <= r_hold;
                        byte_sof   <= r_first;
                        r_first    <= 1'b0;
                    end
                end
            end

            if (w_frame_end) begin
                r_hold_valid <= 1'b0;
                r_first      <= 1'b0;
                if (r_hold_valid) begin
                    byte_valid <= 1'b1;
                    byte_data  <= r_hold;
                    byte_sof   <= r_first;
                    byte_eof   <= 1'b1;
                    frame_len  <= w_len;
                    frame_err  <= w_err;
                    fcs_err    <= w_fcs_bad;
                    if (w_err) begin
                        if (bad_frames != 16'hFFFF) bad_frames <= bad_frames + 16'd1;
                    end else begin
                        if (good_frames != 16'hFFFF) good_frames <= good_frames + 16'd1;
                    end
                end else begin
                    if (bad_frames != 16'hFFFF) bad_frames <= bad_frames + 16'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_eth_mii_rx_framer.sv
// tb_eth_mii_rx_framer: directed scoreboard bench for eth_mii_rx_framer.
// Revision: 1.0
`default_nettype none

module tb_eth_mii_rx_framer;

    localparam int MINB = 64;
    localparam int MAXB = 1518;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nv  = 1'b0;
    logic [3:0]  nd  = 4'h0;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_sof;
    logic        byte_eof;
    logic [10:0] frame_len;
    logic        frame_err;
    logic        fcs_err;
    logic [15:0] good_frames;
    logic [15:0] bad_frames;

    eth_mii_rx_framer #(.MIN_FRAME_BYTES(MINB), .MAX_FRAME_BYTES(MAXB)) dut (
        .eth_mac_clock (clk),
        .eth_mac_rst   (rst),
        .nib_valid     (nv),
        .nib_data      (nd),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_sof      (byte_sof),
        .byte_eof      (byte_eof),
        .frame_len     (frame_len),
        .frame_err     (frame_err),
        .fcs_err       (fcs_err),
        .good_frames   (good_frames),
        .bad_frames    (bad_frames)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  d;
        logic        sof;
        logic        eof;
        logic [10:0] len;
        logic        err;
        logic        fcs;
    } beat_t;

    int         total    = 0;
    int         bad      = 0;
    int         exp_good = 0;
    int         exp_bad  = 0;
    beat_t      q[$];
    logic [7:0] fb[$];

`ifdef ETH_RX_FCS_CHECK_EN
    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] crc_of_fb();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < fb.size(); i++) c = crc_upd(c, fb[i]);
        return c;
    endfunction
`endif

    function automatic logic model_fcs_bad();
`ifdef ETH_RX_FCS_CHECK_EN
        return (crc_of_fb() != 32'hDEBB20E3);
`else
        return 1'b0;
`endif
    endfunction

    // Output monitor: every beat is matched against the head of the scoreboard.
    always @(negedge clk) begin
        beat_t a;
        beat_t e;
        logic  have;
        if (byte_valid) begin
            a.d = byte_data; a.sof = byte_sof; a.eof = byte_eof;
            a.len = frame_len; a.err = frame_err; a.fcs = fcs_err;
            have = (q.size() != 0);
            total++;
            assert (have === 1'b1) else begin
                bad++;
                $error("FAIL unexpected_beat observed=%h expected=none", a);
            end
            if (have) begin
                e = q.pop_front();
                total++;
                assert (a === e) else begin
                    bad++;
                    $error("FAIL beat observed=%h expected=%h", a, e);
                end
            end
        end else begin
            total++;
            assert ({byte_sof, byte_eof} === 2'b00) else begin
                bad++;
                $error("FAIL idle_marker observed=%b expected=00", {byte_sof, byte_eof});
            end
        end
    end

    task automatic step(input logic v, input logic [3:0] d);
        nv = v;
        nd = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int n);
        fb.delete();
        for (int i = 0; i < n; i++) fb.push_back(8'(i));
    endtask

    // Queues the expected beats for fb[], then drives preamble, SFD and data.
    task automatic send_frame(input bit odd, input bit finish);
        int    n;
        int    em;
        logic  fbad;
        logic  err;
        beat_t b;
        n    = fb.size();
        fbad = model_fcs_bad();
        if (finish) begin
            em  = (n > MAXB) ? MAXB : n;
            err = odd || (n < MINB) || (n > MAXB) || fbad;
            for (int i = 0; i < em; i++) begin
                b.d   = fb[i];
                b.sof = (i == 0);
                b.eof = (i == em - 1);
                b.len = (i == em - 1) ? 11'(em) : 11'd0;
                b.err = (i == em - 1) ? err : 1'b0;
                b.fcs = (i == em - 1) ? fbad : 1'b0;
                q.push_back(b);
            end
            if (em == 0 || err) exp_bad++;
            else                exp_good++;
        end else begin
            for (int i = 0; i < n - 1; i++) begin
                b.d = fb[i]; b.sof = (i == 0); b.eof = 1'b0;
                b.len = 11'd0; b.err = 1'b0; b.fcs = 1'b0;
                q.push_back(b);
            end
        end
        for (int i = 0; i < 15; i++) step(1'b1, 4'h5);
        step(1'b1, 4'hD);
        for (int i = 0; i < n; i++) begin
            step(1'b1, fb[i][3:0]);
            step(1'b1, fb[i][7:4]);
        end
        if (odd) step(1'b1, 4'hA);
        if (finish) begin
            step(1'b0, 4'h0);
            step(1'b0, 4'h0);
            step(1'b0, 4'h0);
        end
    endtask

    task automatic chk_after(input string tag);
        chk({tag, "_drain"}, q.size(), 0);
        chk({tag, "_good"}, good_frames, exp_good);
        chk({tag, "_bad"}, bad_frames, exp_bad);
    endtask

    initial begin
        logic [31:0] crc;
        rst = 1'b1;
        step(1'b0, 4'h0);
        step(1'b0, 4'h0);
        step(1'b0, 4'h0);
        chk("rst_valid", byte_valid, 0);
        chk("rst_data", byte_data, 0);
        chk("rst_sof", byte_sof, 0);
        chk("rst_eof", byte_eof, 0);
        chk("rst_len", frame_len, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_fcs", fcs_err, 0);
        chk("rst_good", good_frames, 0);
        chk("rst_bad", bad_frames, 0);
        rst = 1'b0;
        step(1'b0, 4'h0);

        fill(64);  send_frame(1'b0, 1'b1); chk_after("f64");
        fill(63);  send_frame(1'b0, 1'b1); chk_after("f63");
        fill(64);  send_frame(1'b1, 1'b1); chk_after("f64odd");

        step(1'b1, 4'h5); step(1'b1, 4'h5); step(1'b1, 4'h5); step(1'b1, 4'h7);
        step(1'b1, 4'h5); step(1'b1, 4'h5); step(1'b1, 4'hD);
        for (int i = 0; i < 8; i++) step(1'b1, 4'(i));
        step(1'b0, 4'h0); step(1'b0, 4'h0); step(1'b0, 4'h0);
        chk_after("badpre");
        fill(64);  send_frame(1'b0, 1'b1); chk_after("after_badpre");

        fill(0);   send_frame(1'b0, 1'b1); chk_after("empty");
        fb.delete(); fb.push_back(8'hA5);
        send_frame(1'b0, 1'b1); chk_after("one_byte");

        fill(MAXB);     send_frame(1'b0, 1'b1); chk_after("max");
        fill(MAXB + 1); send_frame(1'b0, 1'b1); chk_after("over_max");

`ifdef ETH_RX_FCS_CHECK_EN
        fill(60);
        crc = ~crc_of_fb();
        for (int k = 0; k < 4; k++) fb.push_back(crc[8*k +: 8]);
        send_frame(1'b0, 1'b1); chk_after("fcs_good");
        fb[62] = fb[62] ^ 8'h10;
        send_frame(1'b0, 1'b1); chk_after("fcs_flip");
`else
        crc = 32'h0;
`endif

        fill(20); send_frame(1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1, 4'h3);
        rst = 1'b0;
        exp_good = 0;
        exp_bad  = 0;
        chk("midrst_valid", byte_valid, 0);
        chk("midrst_eof", byte_eof, 0);
        chk("midrst_data", byte_data, 0);
        chk("midrst_good", good_frames, 0);
        chk("midrst_bad", bad_frames, 0);
        chk("midrst_drain", q.size(), 0);
        step(1'b0, 4'h0);
        step(1'b0, 4'h0);
        fill(64); send_frame(1'b0, 1'b1); chk_after("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
